// File: rtl/mem_bist_pkg.sv
// Shared definitions for the memory BIST master.
//   - state_e    : BIST sequencer states
//   - *_DEF      : default address width, data width and pattern seed
//   - pattern()  : expected word for an address, optionally inverted
package mem_bist_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 8;
  localparam logic [7:0]  SEED_DEF   = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRd,
    StDrain,
    StDone
  } state_e;

  // Expected data is addr ^ seed, bitwise inverted on the inverted pass.
  // Callers truncate the result to their data width.
  function automatic logic [31:0] pattern(input logic [31:0] addr, input logic inv,
                                          input logic [31:0] seed);
    logic [31:0] p;
    p = addr ^ seed;
    return inv ? ~p : p;
  endfunction

endpackage

// File: rtl/mem_bist_errlog.sv
// Read-back comparator and error log for the memory BIST.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   clear           clears the log at the start of a run
//   cmp_valid       act/exp/exp_addr hold a read-back to compare this cycle
//   exp, act        expected and actual read data
//   exp_addr        address the read-back belongs to
//   miscmp          combinational: this cycle's compare fails
//   err_count       saturating miscompare count
//   first_err_addr  address of the first miscompare since clear, 0 if none
module mem_bist_errlog #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              cmp_valid,
  input  logic [DATA_W-1:0] exp,
  input  logic [DATA_W-1:0] act,
  input  logic [ADDR_W-1:0] exp_addr,
  output logic              miscmp,
  output logic [ADDR_W+1:0] err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  logic [ADDR_W+1:0] err_count_q, err_count_d;
  logic [ADDR_W-1:0] first_err_addr_q, first_err_addr_d;

  assign miscmp = cmp_valid && (act != exp);

  always_comb begin
    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;
    if (clear) begin
      err_count_d      = '0;
      first_err_addr_d = '0;
    end else if (miscmp) begin
      if (err_count_q != '1) begin
        err_count_d = err_count_q + 1'b1;
      end
      // Count is zero only before the first error; saturation never wraps it back.
      if (err_count_q == '0) begin
        first_err_addr_d = exp_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_q      <= '0;
      first_err_addr_q <= '0;
    end else begin
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
    end
  end

  assign err_count      = err_count_q;
  assign first_err_addr = first_err_addr_q;

endmodule

// File: rtl/mem_bist_master.sv
// Memory BIST bus initiator: writes pattern(a) to every address, reads every address back,
// compares one cycle after each read and reports a pass/fail summary.
// Optional feature macro MEM_BIST_INV_PASS_EN: when defined, a second write/read pass with
// the inverted pattern follows the first; errors accumulate across both passes.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start           run request, honoured only when idle
//   busy            high from the cycle after start is accepted through the done cycle
//   done            one-cycle end-of-test pulse
//   pass            no miscompares in the last run; held until the next accepted start
//   err_count       saturating miscompare count
//   first_err_addr  address of the first miscompare, 0 if none
//   write, read     registered memory strobes, never both high
//   addr, data_in   registered memory address and write data
//   data_out        memory read data, valid the cycle after read is sampled
module mem_bist_master
  import mem_bist_pkg::*;
#(
  parameter int unsigned       ADDR_W = ADDR_W_DEF,
  parameter int unsigned       DATA_W = DATA_W_DEF,
  parameter logic [DATA_W-1:0] SEED   = DATA_W'(SEED_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W+1:0] err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              write,
  output logic              read,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out
);

  localparam logic [ADDR_W-1:0] LastAddr = '1;

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input logic inv);
    return DATA_W'(pattern(32'(a), inv, 32'(SEED)));
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic              write_q, write_d;
  logic              read_q, read_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              inv_q, inv_d;          // current pass uses the inverted pattern
  logic              cmp_valid_q, cmp_valid_d;
  logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
  logic              exp_inv_q, exp_inv_d;
  logic              clear;
  logic              miscmp;
  logic              run_inv_pass;

`ifdef MEM_BIST_INV_PASS_EN
  assign run_inv_pass = ~inv_q;
`else
  assign run_inv_pass = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_in_d   = data_in_q;
    write_d     = 1'b0;
    read_d      = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    inv_d       = inv_q;
    // A read issued this cycle is checked next cycle against its own address.
    cmp_valid_d = read_q;
    exp_addr_d  = addr_q;
    exp_inv_d   = inv_q;
    clear       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StWr;
          write_d   = 1'b1;
          addr_d    = '0;
          data_in_d = pat('0, 1'b0);
          busy_d    = 1'b1;
          pass_d    = 1'b0;
          inv_d     = 1'b0;
          clear     = 1'b1;
        end
      end
      StWr: begin
        if (addr_q == LastAddr) begin
          state_d = StRd;
          read_d  = 1'b1;
          addr_d  = '0;
        end else begin
          write_d   = 1'b1;
          addr_d    = addr_q + 1'b1;
          data_in_d = pat(addr_q + 1'b1, inv_q);
        end
      end
      StRd: begin
        if (addr_q == LastAddr) begin
          state_d = StDrain;
          addr_d  = '0;
        end else begin
          read_d = 1'b1;
          addr_d = addr_q + 1'b1;
        end
      end
      StDrain: begin
        if (run_inv_pass) begin
          state_d   = StWr;
          inv_d     = 1'b1;
          write_d   = 1'b1;
          addr_d    = '0;
          data_in_d = pat('0, 1'b1);
        end else begin
          state_d = StDone;
          done_d  = 1'b1;
          // Include the last compare, which lands on this same edge.
          pass_d  = (err_count == '0) && !miscmp;
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      data_in_q   <= '0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      inv_q       <= 1'b0;
      cmp_valid_q <= 1'b0;
      exp_addr_q  <= '0;
      exp_inv_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_in_q   <= data_in_d;
      write_q     <= write_d;
      read_q      <= read_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      inv_q       <= inv_d;
      cmp_valid_q <= cmp_valid_d;
      exp_addr_q  <= exp_addr_d;
      exp_inv_q   <= exp_inv_d;
    end
  end

  mem_bist_errlog #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_errlog (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .cmp_valid     (cmp_valid_q),
    .exp           (pat(exp_addr_q, exp_inv_q)),
    .act           (data_out),
    .exp_addr      (exp_addr_q),
    .miscmp        (miscmp),
    .err_count     (err_count),
    .first_err_addr(first_err_addr)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign write   = write_q;
  assign read    = read_q;
  assign addr    = addr_q;
  assign data_in = data_in_q;

endmodule

// File: tb/tb_mem_bist_master.sv
// Self-checking bench for mem_bist_master: a memory model with injectable stuck-at bits,
// a reference model of the BIST result, and a negedge monitor fed by a scoreboard queue.
module tb_mem_bist_master;

  localparam int DEPTH = 32;
`ifdef MEM_BIST_INV_PASS_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif
  localparam int DONE_LAT = (NPASS == 2) ? 131 : 66;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, pass, write, read;
  logic [6:0] err_count;
  logic [4:0] first_err_addr, addr;
  logic [7:0] data_in;
  logic [7:0] data_out = 8'h00;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  int overlap = 0;

  typedef struct {
    int   done_cyc;
    int   errs;
    int   first;
    logic pass;
  } exp_t;
  exp_t sb[$];

  logic [7:0] mem [DEPTH];
  logic       flt_en [DEPTH];
  int         flt_bit [DEPTH];
  logic       flt_val [DEPTH];

  mem_bist_master dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_addr(first_err_addr),
    .write         (write),
    .read          (read),
    .addr          (addr),
    .data_in       (data_in),
    .data_out      (data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] faulty(input logic [7:0] v, input int a);
    logic [7:0] r;
    r = v;
    if (flt_en[a]) r[flt_bit[a]] = flt_val[a];
    return r;
  endfunction

  // Synchronous memory: write captured on the edge, read data registered on the edge.
  always @(posedge clk) begin
    if (write) mem[addr] <= data_in;
    if (read) data_out <= faulty(mem[addr], int'(addr));
  end

  function automatic logic [7:0] ref_pat(input int a, input int p);
    logic [7:0] v;
    v = 8'(a) ^ 8'hA5;
    return (p != 0) ? ~v : v;
  endfunction

  // Expected result: every pass writes every word then reads it back through the faults.
  function automatic exp_t model();
    exp_t e;
    logic [7:0] w;
    e.errs = 0;
    e.first = 0;
    e.done_cyc = 0;
    for (int p = 0; p < NPASS; p++) begin
      for (int a = 0; a < DEPTH; a++) begin
        w = ref_pat(a, p);
        if (faulty(w, a) != w) begin
          if (e.errs == 0) e.first = a;
          if (e.errs < 127) e.errs++;
        end
      end
    end
    e.pass = (e.errs == 0);
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic monitor();
    logic busy_prev = 1'b0;
    int   wr_idx = 0;
    int   rd_idx = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (read && write) overlap++;
      if (busy && !busy_prev) begin
        wr_idx = 0;
        rd_idx = 0;
      end
      busy_prev = busy;
      if (write) begin
        check("wr_addr", 32'(addr), 32'(wr_idx % DEPTH));
        check("wr_data", 32'(data_in), 32'(ref_pat(wr_idx % DEPTH, wr_idx / DEPTH)));
        wr_idx++;
      end
      if (read) begin
        check("rd_addr", 32'(addr), 32'(rd_idx % DEPTH));
        rd_idx++;
      end
      if (done) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done: got done with no run pending (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.done_cyc));
          check("err_count", 32'(err_count), 32'(e.errs));
          check("first_err_addr", 32'(first_err_addr), 32'(e.first));
          check("pass", 32'(pass), 32'(e.pass));
        end
      end
    end
  endtask

  task automatic clear_faults();
    for (int a = 0; a < DEPTH; a++) begin
      flt_en[a]  = 1'b0;
      flt_bit[a] = 0;
      flt_val[a] = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!busy) return;
      @(negedge clk);
    end
    n_total++;
    $display("FAIL idle_timeout: busy still 1 expected 0 (cycle %0d)", cyc);
  endtask

  // stray: 0 none, 1 start pulse 20 cycles in, 2 random start pulses while busy
  task automatic run(input int stray);
    exp_t e;
    bit   seen;
    wait_idle();
    e = model();
    @(negedge clk);
    start = 1'b1;
    e.done_cyc = cyc + DONE_LAT;
    sb.push_back(e);
    seen = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      start = (stray == 1 && t == 19) || (stray == 2 && $urandom_range(0, 7) == 0);
    end
    start = 1'b0;
    if (!seen) begin
      n_total++;
      $display("FAIL done_timeout: done never seen, expected at cycle %0d", e.done_cyc);
      sb.delete();
    end
    wait_idle();
    @(negedge clk);
    check("pass_hold", 32'(pass), 32'(e.pass));
    check("errs_hold", 32'(err_count), 32'(e.errs));
  endtask

  initial begin
    exp_t e;
    bit   hit;
    int   nf, a;
    clear_faults();
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_write", 32'(write), 0);
    check("rst_read", 32'(read), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_err_count", 32'(err_count), 0);
    check("rst_first_err", 32'(first_err_addr), 0);
    check("rst_addr", 32'(addr), 0);
    check("rst_data_in", 32'(data_in), 0);
    reset = 1'b0;

    // Clean memory.
    run(0);

    // Bit 0 stuck at 1 at address 5.
    flt_en[5]  = 1'b1;
    flt_bit[5] = 0;
    flt_val[5] = 1'b1;
    run(0);
    clear_faults();

    // start while busy must be ignored.
    run(1);

    // Reset during the write phase at address 10.
    wait_idle();
    e = model();
    @(negedge clk);
    start = 1'b1;
    e.done_cyc = cyc + DONE_LAT;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (write && addr == 5'd10) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!hit) begin
      n_total++;
      $display("FAIL reach_addr10: write at addr 10 never seen (cycle %0d)", cyc);
    end
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midrst_write", 32'(write), 0);
    check("midrst_read", 32'(read), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_err_count", 32'(err_count), 0);
    check("midrst_done", 32'(done), 0);
    reset = 1'b0;
    run(0);

    // Randomized stuck-at faults and stray starts.
    for (int r = 0; r < 8; r++) begin
      clear_faults();
      nf = $urandom_range(0, 3);
      for (int k = 0; k < nf; k++) begin
        a = $urandom_range(0, DEPTH - 1);
        flt_en[a]  = 1'b1;
        flt_bit[a] = $urandom_range(0, 7);
        flt_val[a] = 1'($urandom_range(0, 1));
      end
      run($urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    check("no_rw_overlap", 32'(overlap), 0);
    check("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
